// File: rtl/inst_fetch_pkg.sv
// +-----------------------------------------------------------------------------
// | Module      : inst_fetch_pkg
// | Description : Shared bus widths, reset PC and fetch-entry type for the fetch stage.
// | Revision    : 1.0 - initial release
// +-----------------------------------------------------------------------------
`default_nettype none

`ifndef ADDR_BUS
`define ADDR_BUS 31:0
`endif
`ifndef DATA_BUS
`define DATA_BUS 31:0
`endif
`ifndef MEM_SEL_BUS
`define MEM_SEL_BUS 3:0
`endif
`ifndef INIT_PC
`define INIT_PC 32'h0000_1000
`endif
`ifndef FETCH_ENTRY_W
`define FETCH_ENTRY_W 64
`endif

package inst_fetch_pkg;

  localparam int unsigned c_ADDR_W  = 32;
  localparam int unsigned c_DATA_W  = 32;
  localparam int unsigned c_ENTRY_W = `FETCH_ENTRY_W;

  typedef struct packed {
    logic [c_ADDR_W-1:0] pc;
    logic [c_DATA_W-1:0] inst;
  } fetch_entry_t;

  // Redirect targets are forced onto a word boundary.
  function automatic logic [c_ADDR_W-1:0] align_pc(input logic [c_ADDR_W-1:0] a);
    return {a[c_ADDR_W-1:2], 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/inst_fetch_buffer.sv
// +-----------------------------------------------------------------------------
// | Module      : fetch_buffer
// | Description : Synchronous FIFO holding fetched {pc, inst} entries; clear wins.
// | Revision    : 1.0 - initial release
// +-----------------------------------------------------------------------------
`default_nettype none

module fetch_buffer #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full,
  output logic [WIDTH-1:0] head
);

  localparam logic [CNT_W-1:0] c_DEPTH = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty = (r_count == '0);
  assign full  = (r_count == c_DEPTH);
  assign count = r_count;
  assign head  = r_mem[r_rd_ptr];

  // A push into a full buffer is only taken when the head leaves in the same cycle.
  assign w_do_pop  = pop && !clear && !empty;
  assign w_do_push = push && !clear && (!full || w_do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (clear) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/inst_fetch.sv
// +-----------------------------------------------------------------------------
// | Module      : inst_fetch
// | Description : Fetch stage: owns the PC, issues ROM reads, buffers returned words.
// |               Optional IF_PERF_CNT_EN adds fetch/stall performance counters.
// | Revision    : 1.0 - initial release
// +-----------------------------------------------------------------------------
`default_nettype none

module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int BUF_DEPTH = 2,
  parameter int PC_STEP   = 4
) (
  input  logic                clk,
  input  logic                rst,
  output logic                rom_en,
  output logic [`MEM_SEL_BUS] rom_write_en,
  output logic [`ADDR_BUS]    rom_addr,
  output logic [`DATA_BUS]    rom_write_data,
  input  logic [`DATA_BUS]    rom_read_data,
  input  logic                flush,
  input  logic [`ADDR_BUS]    flush_pc,
  input  logic                inst_ready,
  output logic                inst_valid,
  output logic [`DATA_BUS]    inst,
  output logic [`ADDR_BUS]    inst_pc
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]         perf_fetch_cnt,
  output logic [31:0]         perf_stall_cnt
`endif
);

  localparam int                 c_CNT_W   = $clog2(BUF_DEPTH) + 1;
  localparam logic [c_CNT_W:0]   c_DEPTH   = (c_CNT_W + 1)'(BUF_DEPTH);
  localparam logic [c_ADDR_W-1:0] c_PC_STEP = c_ADDR_W'(PC_STEP);

  logic [c_ADDR_W-1:0] r_pc;
  logic [c_ADDR_W-1:0] r_inflight_pc;
  logic                r_run;
  logic                r_inflight;
  logic                r_kill;

  logic [c_CNT_W-1:0]  w_count;
  logic [c_CNT_W:0]    w_occupancy;
  logic                w_empty;
  logic                w_full;
  logic                w_pop;
  logic                w_push;
  logic                w_issue;
  fetch_entry_t        w_head;
  fetch_entry_t        w_push_entry;

  assign w_pop       = inst_valid && inst_ready;
  // Credit: buffered entries plus the outstanding response must leave room.
  assign w_occupancy = {1'b0, w_count} + {{c_CNT_W{1'b0}}, r_inflight};
  assign w_issue     = r_run && !flush && ((w_occupancy < c_DEPTH) || w_pop);
  assign w_push      = r_inflight && !r_kill;

  assign w_push_entry.pc   = r_inflight_pc;
  assign w_push_entry.inst = rom_read_data;

  assign rom_en         = w_issue;
  assign rom_addr       = r_pc;
  assign rom_write_en   = '0;
  assign rom_write_data = '0;

  assign inst_valid = !w_empty;
  assign inst       = inst_valid ? w_head.inst : '0;
  assign inst_pc    = inst_valid ? w_head.pc   : '0;

  fetch_buffer #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (c_ENTRY_W)
  ) u_fetch_buffer (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .push      (w_push),
    .push_data (w_push_entry),
    .pop       (w_pop),
    .count     (w_count),
    .empty     (w_empty),
    .full      (w_full),
    .head      (w_head)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc          <= `INIT_PC;
      r_inflight_pc <= '0;
      r_run         <= 1'b0;
      r_inflight    <= 1'b0;
      r_kill        <= 1'b0;
    end else begin
      r_run  <= 1'b1;
      r_kill <= flush;
      if (flush) begin
        r_pc       <= align_pc(flush_pc);
        r_inflight <= 1'b0;
      end else begin
        r_inflight <= w_issue;
        if (w_issue) begin
          r_pc          <= r_pc + c_PC_STEP;
          r_inflight_pc <= r_pc;
        end
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_stall_cnt;

  // Saturating counters; a redirect does not clear them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_pop && (r_fetch_cnt != 32'hFFFF_FFFF))
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (inst_valid && !inst_ready && (r_stall_cnt != 32'hFFFF_FFFF))
        r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign perf_fetch_cnt = r_fetch_cnt;
  assign perf_stall_cnt = r_stall_cnt;
`endif

  logic w_unused;
  assign w_unused = w_full;

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch.sv
// +-----------------------------------------------------------------------------
// | Module      : tb_inst_fetch
// | Description : Directed self-checking bench for inst_fetch.
// | Revision    : 1.0 - initial release
// +-----------------------------------------------------------------------------
`default_nettype none

module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        rom_en;
  logic [3:0]  rom_write_en;
  logic [31:0] rom_addr;
  logic [31:0] rom_write_data;
  logic [31:0] rom_read_data = '0;
  logic        flush;
  logic [31:0] flush_pc;
  logic        inst_ready;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [31:0] c_INIT = 32'h0000_1000;

  always #5 clk = ~clk;

  inst_fetch #(.BUF_DEPTH(2), .PC_STEP(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .rom_en         (rom_en),
    .rom_write_en   (rom_write_en),
    .rom_addr       (rom_addr),
    .rom_write_data (rom_write_data),
    .rom_read_data  (rom_read_data),
    .flush          (flush),
    .flush_pc       (flush_pc),
    .inst_ready     (inst_ready),
    .inst_valid     (inst_valid),
    .inst           (inst),
`ifdef IF_PERF_CNT_EN
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt),
`endif
    .inst_pc        (inst_pc)
  );

  // ROM word k (byte address c_INIT + 4k) holds 0x1000_0000 + k.
  function automatic logic [31:0] rom_word(input logic [31:0] addr);
    return 32'h1000_0000 + ((addr - c_INIT) >> 2);
  endfunction

  always @(posedge clk) if (rom_en) rom_read_data <= rom_word(rom_addr);

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  typedef struct {
    logic        ready;
    logic        exp_en;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_inst;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t tbl [12];

  // Flush in the current cycle F, then check F+1 .. F+3; returns at negedge F+4.
  task automatic flush_seq(input string name, input logic [31:0] target, input logic [31:0] exp_pc);
    flush = 1'b1; flush_pc = target;
    #1 chk({name, "_F_en"}, rom_en, 0);
    @(negedge clk); flush = 1'b0;
    #1 chk({name, "_F1_en"}, rom_en, 1);
    chk({name, "_F1_addr"}, rom_addr, exp_pc);
    chk({name, "_F1_valid"}, inst_valid, 0);
    @(negedge clk);
    #1 chk({name, "_F2_valid"}, inst_valid, 0);
    chk({name, "_F2_addr"}, rom_addr, exp_pc + 32'd4);
    @(negedge clk);
    #1 chk({name, "_F3_valid"}, inst_valid, 1);
    chk({name, "_F3_pc"}, inst_pc, exp_pc);
    chk({name, "_F3_inst"}, inst, rom_word(exp_pc));
    @(negedge clk);
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 32'h1000, 1'b0, 32'h0, 32'h0};
    tbl[1]  = '{1'b1, 1'b1, 32'h1000, 1'b0, 32'h0, 32'h0};
    tbl[2]  = '{1'b1, 1'b1, 32'h1004, 1'b0, 32'h0, 32'h0};
    tbl[3]  = '{1'b0, 1'b0, 32'h1008, 1'b1, 32'h1000_0000, 32'h1000};
    tbl[4]  = '{1'b0, 1'b0, 32'h1008, 1'b1, 32'h1000_0000, 32'h1000};
    tbl[5]  = '{1'b0, 1'b0, 32'h1008, 1'b1, 32'h1000_0000, 32'h1000};
    tbl[6]  = '{1'b0, 1'b0, 32'h1008, 1'b1, 32'h1000_0000, 32'h1000};
    tbl[7]  = '{1'b0, 1'b0, 32'h1008, 1'b1, 32'h1000_0000, 32'h1000};
    tbl[8]  = '{1'b1, 1'b1, 32'h1008, 1'b1, 32'h1000_0000, 32'h1000};
    tbl[9]  = '{1'b1, 1'b1, 32'h100C, 1'b1, 32'h1000_0001, 32'h1004};
    tbl[10] = '{1'b1, 1'b1, 32'h1010, 1'b1, 32'h1000_0002, 32'h1008};
    tbl[11] = '{1'b1, 1'b1, 32'h1014, 1'b1, 32'h1000_0003, 32'h100C};

    rst = 1'b0; flush = 1'b0; flush_pc = '0; inst_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_en", rom_en, 0);
    chk("rst_addr", rom_addr, c_INIT);
    chk("rst_valid", inst_valid, 0);
    chk("rst_inst", inst, 0);
    chk("rst_pc", inst_pc, 0);

    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      inst_ready = tbl[i].ready;
      #1;
      chk($sformatf("v%0d_en", i), rom_en, tbl[i].exp_en);
      chk($sformatf("v%0d_addr", i), rom_addr, tbl[i].exp_addr);
      chk($sformatf("v%0d_valid", i), inst_valid, tbl[i].exp_valid);
      chk($sformatf("v%0d_inst", i), inst, tbl[i].exp_inst);
      chk($sformatf("v%0d_pc", i), inst_pc, tbl[i].exp_pc);
      @(negedge clk);
    end
`ifdef IF_PERF_CNT_EN
    chk("perf_fetch", perf_fetch_cnt, 4);
    chk("perf_stall", perf_stall_cnt, 5);
`endif

    // Steady stream, one word in flight, flush collides with a pop.
    inst_ready = 1'b1;
    #1 chk("pre_flush_valid", inst_valid, 1);
    chk("pre_flush_pc", inst_pc, 32'h1010);
    flush_seq("flushA", c_INIT + 32'h40, c_INIT + 32'h40);
    flush_seq("flushB", c_INIT + 32'h43, c_INIT + 32'h40);

    // Back-to-back flushes: only the second target stream may appear.
    flush = 1'b1; flush_pc = c_INIT + 32'h10;
    #1 chk("dbl_F_en", rom_en, 0);
    @(negedge clk); flush_pc = c_INIT + 32'h20;
    #1 chk("dbl_F1_en", rom_en, 0);
    chk("dbl_F1_valid", inst_valid, 0);
    @(negedge clk); flush = 1'b0;
    #1 chk("dbl_F2_addr", rom_addr, c_INIT + 32'h20);
    chk("dbl_F2_en", rom_en, 1);
    @(negedge clk);
    #1 chk("dbl_F3_valid", inst_valid, 0);
    @(negedge clk);
    #1 chk("dbl_F4_pc", inst_pc, c_INIT + 32'h20);
    chk("dbl_F4_inst", inst, rom_word(c_INIT + 32'h20));
    @(negedge clk);
    #1 chk("dbl_F5_pc", inst_pc, c_INIT + 32'h24);

    // PC wrap past the top of the address space.
    @(negedge clk);
    flush_seq("wrap", 32'hFFFF_FFF8, 32'hFFFF_FFF8);
    #1 chk("wrap_pc1", inst_pc, 32'hFFFF_FFFC);
    @(negedge clk);
    #1 chk("wrap_pc2", inst_pc, 32'h0000_0000);
    chk("wrap_inst2", inst, rom_word(32'h0));

    // Asynchronous reset between edges.
    @(posedge clk); #3 rst = 1'b0;
    #1 chk("arst_en", rom_en, 0);
    chk("arst_valid", inst_valid, 0);
    chk("arst_addr", rom_addr, c_INIT);
    chk("arst_inst", inst, 0);
`ifdef IF_PERF_CNT_EN
    chk("arst_perf_fetch", perf_fetch_cnt, 0);
    chk("arst_perf_stall", perf_stall_cnt, 0);
`endif
    @(negedge clk); rst = 1'b1;
    #1 chk("rel_c0_en", rom_en, 0);
    @(negedge clk);
    #1 chk("rel_c1_en", rom_en, 1);
    chk("rel_c1_addr", rom_addr, c_INIT);
    @(negedge clk);
    @(negedge clk);
    #1 chk("rel_c3_valid", inst_valid, 1);
    chk("rel_c3_inst", inst, 32'h1000_0000);
    chk("rel_c3_pc", inst_pc, c_INIT);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction-fetch stage directly upstream of the instruction ROM.
- Owns the fetch PC and drives the ROM request port.
- Captures the ROM's one-cycle-latency read data into a small FIFO.
- Presents {pc, inst} to decode over a valid/ready handshake, and accepts redirects (branch/jump/exception) through a flush port.

Parameters:
- BUF_DEPTH, 2: fetch buffer entries; minimum 2; power of two.
- PC_STEP, 4: byte increment per sequential fetch.

Ports:
- clk  in  1  clock; all flops on rising edge.
- rst  in  1  asynchronous, active-low reset.
- rom_en  out  1  ROM read enable; one request per cycle when high.
- rom_write_en  out  `MEM_SEL_BUS  tied to 0.
- rom_addr  out  `ADDR_BUS  absolute fetch address; the ROM subtracts `INIT_PC.
- rom_write_data  out  `DATA_BUS  tied to 0.
- rom_read_data  in  `DATA_BUS  ROM data; valid the cycle after rom_en was sampled.
- flush  in  1  redirect request.
- flush_pc  in  `ADDR_BUS  redirect target.
- inst_ready  in  1  decode accepts the head entry.
- inst_valid  out  1  head entry valid.
- inst  out  `DATA_BUS  instruction word, passed through unmodified.
- inst_pc  out  `ADDR_BUS  address of inst.

Behaviour:
- Reset (rst low, asynchronous): all state clears.
  - pc_q = `INIT_PC; run_q = 0; inflight_q = 0; buffer empty.
  - Outputs: rom_en = 0, rom_addr = `INIT_PC, inst_valid = 0, inst = 0, inst_pc = 0.
- run_q sets on the first clk edge after rst rises. rom_en is gated by run_q, so no request is issued in the reset-release cycle.
- Issue rule:
  - rom_en = run_q && !flush && (count + inflight_q < BUF_DEPTH || pop).
  - pop = inst_valid && inst_ready.
  - rom_addr = pc_q.
  - When rom_en is high, at the edge: pc_q += PC_STEP (32-bit wrap, 0xFFFF_FFFC -> 0x0000_0000), inflight_q = 1, inflight_pc_q = pc_q.
- Response: in the cycle after issue, if inflight_q and the request is not killed, {inflight_pc_q, rom_read_data} is pushed at the edge. inflight_q clears unless a new issue occurs.
- Latency:
  - Request in cycle N, data on rom_read_data in N+1, inst_valid in N+2.
  - Steady state with inst_ready held high gives one instruction per cycle.
- Handshake:
  - The head is held stable (inst, inst_pc unchanged) while inst_valid && !inst_ready.
  - inst_valid never drops without a pop or a flush.
- Full: credit rule guarantees no push into a full buffer. With inst_ready low, fetch stops at count = BUF_DEPTH, inflight 0.
- Flush (highest priority):
  - At the edge: buffer cleared; any concurrent pop ignored; pc_q = {flush_pc[31:2], 2'b00}; inflight response killed (kill_q set, so next cycle's rom_read_data is discarded).
  - No issue in the flush cycle. First redirected request in cycle F+1; redirected inst_valid in F+3.
- Back-to-back flush: the last one wins; each kills any outstanding response.
- Reset mid-operation: all state lost immediately; restart from `INIT_PC.

Optional Feature:
- IF_PERF_CNT_EN defined:
  - Adds outputs perf_fetch_cnt (32b, increments on each pop) and perf_stall_cnt (32b, increments each cycle inst_valid && !inst_ready).
  - Both reset to 0, saturate at 0xFFFF_FFFF, and are not cleared by flush.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package/include: ADDR_BUS, DATA_BUS, MEM_SEL_BUS (bus.v); `INIT_PC (pcdef.v); new `FETCH_ENTRY_W = 64 ({pc, inst}).
- One sub-module, fetch_buffer:
  - Parameterised synchronous FIFO (push, pop, clear, count, head).
  - Same async active-low rst.
  - clear dominates push/pop.
  - Simultaneous push and pop on a full buffer is legal.

Test Plan:
- Reset release, ROM word k = 0x1000_0000+k, inst_ready=1 -> first rom_en in cycle 1 with addr `INIT_PC; inst_valid cycle 3; inst 0x1000_0000/0x1000_0001/... with inst_pc `INIT_PC, +4, +8, one per cycle.
- inst_ready=0 from cycle 3 for 5 cycles -> exactly BUF_DEPTH=2 entries held, head stable, rom_en low after credit exhausted; release -> resumes without loss or duplication.
- flush=1, flush_pc=`INIT_PC+0x40 while one request in flight -> in-flight word discarded; next inst_valid 3 cycles later with inst_pc `INIT_PC+0x40.
- flush with flush_pc=`INIT_PC+0x43 -> fetches `INIT_PC+0x40.
- Flush in the same cycle as a pop, and two consecutive flushes (targets +0x10 then +0x20) -> only the +0x20 stream appears.
- rst low mid-stream (async, between edges) -> inst_valid and rom_en drop immediately; after release, restart at `INIT_PC. With IF_PERF_CNT_EN, counters read 0.
